multicycle_mips_core: RTL and testbench
=======================================

Name: multicycle_mips_core

Overview:
- Parametrised multi-cycle successor to the team's single-cycle MIPS datapath.
- Executes the same subset: add, sub, and, or, slt, lw, sw, beq, j, jal, jr.
- Uses one unified instruction/data memory port with a req/ready handshake, so slow SRAM (wait states) is tolerated.
- Adds a TRAP state for illegal opcodes and misaligned accesses; exports a register-file write trace port for the testbench.

Parameters:
- ADDR_W, 7, word-address width of the memory port.
- RESET_PC, 32'h0000_0000, byte PC loaded on reset.
- NREGS, 32, number of GPRs; must be 32 or 16. Register index is 5 bits; with NREGS=16, accesses to r16-r31 trap.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  ADDR_W  word address (byte address bits [ADDR_W+1:2])
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data; valid in the cycle mem_ready=1
- mem_ready  in  1  transaction completes in a cycle where mem_req=1 and mem_ready=1
- rf_wen  out  1  one-cycle pulse on each GPR write (never for r0)
- rf_waddr  out  5  written register
- rf_wdata  out  32  written value
- pc  out  32  byte address of the current instruction
- trap  out  1  sticky; core halted

Behaviour:
- Reset (async, rst=1): state=FETCH, pc=RESET_PC, all GPRs 0. Outputs mem_req, mem_we, rf_wen, trap = 0; mem_addr, mem_wdata, rf_waddr, rf_wdata = 0.
- Reset mid-transaction: mem_req drops immediately and the access is abandoned. The first FETCH after rst deasserts issues at the next rising edge.
- State machine:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc[ADDR_W+1:2]. Stays in FETCH until mem_ready; then latches IR → DECODE.
  - DECODE: reads rs/rt and sign-extends imm.
    - j: pc={pc+4[31:28], target, 2'b00} → FETCH.
    - jal: r31=pc+4 (rf_wen pulse), pc as for j → FETCH.
    - R-type with funct jr: pc=rs → FETCH.
    - Unknown opcode or funct → TRAP.
    - Otherwise → EXEC.
  - EXEC:
    - R-type: ALU computes → WB.
    - lw/sw: addr=rs+simm. Byte address bits [1:0] ≠ 0 → TRAP, else → MEM.
    - beq: if rs==rt then pc=pc+4+(simm<<2), else pc=pc+4 → FETCH.
  - MEM: mem_req=1, mem_we=is_sw, mem_wdata=rt. Holds until mem_ready.
    - sw: pc+=4 → FETCH.
    - lw: latches mem_rdata into MDR → WB.
  - WB: writes rd (R-type) or rt (lw), pulses rf_wen, pc+=4 → FETCH.
  - TRAP: absorbing; trap=1, mem_req=0. Exits only via reset.
- Handshake:
  - While mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata must stay stable.
  - mem_ready while mem_req=0 is ignored.
  - mem_req is deasserted in the cycle after a completion unless the next state also requests.
- Latency with zero wait states (cycles per instruction):
  - j / jal / jr: 2
  - beq: 3
  - R-type: 4
  - sw: 4
  - lw: 5
  - Each wait cycle adds 1.
- Arithmetic:
  - 32-bit wrap-around add/sub.
  - slt is signed.
  - Memory address truncation beyond ADDR_W is silent.
- Register r0:
  - Always reads 0.
  - Writes to r0 are dropped and produce no rf_wen pulse.
- Trace port: rf_wen is a registered pulse in the write cycle; rf_wdata holds its last value otherwise.

Decomposition:
- Shared package mips_pkg:
  - opcode constants: RTYPE, LW, SW, BEQ, J, JAL
  - funct constants: ADD, SUB, AND, OR, SLT, JR
  - state enum: FETCH, DECODE, EXEC, MEM, WB, TRAP
  - 3-bit alu_op enum
- One sub-module, mips_alu: combinational 32-bit ALU taking alu_op and producing result and zero.
- Register file and FSM stay in the top module.

Test Plan:
- Reset with rst held mid-FETCH (mem_req=1) → mem_req=0 in the same cycle; after release pc=0 and first mem_addr=0.
- Program addi-free R-type sequence: lw r1←mem[8]=5, lw r2←mem[9]=7, add r3,r1,r2, slt r4,r2,r1 → rf_wen trace (1,5), (2,7), (3,12), (4,0); with zero waits, lw+lw+add+slt completes in 18 cycles.
- Same program with mem_ready delayed 3 cycles on every access → identical trace, addresses stable throughout each stall, cycle count 18 + 3×(number of accesses).
- beq r1,r1,-1 when r1==r1 → pc repeats the same address; beq r1,r2,+2 with r1≠r2 → pc+4.
- jal to 0x40 then jr r31 → r31=pc_jal+4, then pc returns to pc_jal+4; writing r0 via add r0,r1,r1 → no rf_wen pulse, r0 reads 0.
- Opcode 6'b111111, or lw with offset 2 → trap=1 within 2 or 3 cycles, mem_req stays 0, cleared only by rst.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings, FSM state codes and ALU operation set for the multi-cycle MIPS core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    typedef logic [2:0] state_t;
    localparam state_t FETCH  = 3'd0;
    localparam state_t DECODE = 3'd1;
    localparam state_t EXEC   = 3'd2;
    localparam state_t MEM    = 3'd3;
    localparam state_t WB     = 3'd4;
    localparam state_t TRAP   = 3'd5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] sign_ext(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU; zero flag drives the beq decision.
module mips_alu
    import mips_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = a + b;
        case (op)
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
            default: result = a + b;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/multicycle_mips_core.sv
// Multi-cycle MIPS subset core sharing one req/ready memory port for fetch and data.
module multicycle_mips_core
    import mips_pkg::*;
#(
    parameter int          ADDR_W   = 7,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              rf_wen,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [31:0]       pc,
    output logic              trap
);

    localparam int IW = (NREGS == 16) ? 4 : 5;

    state_t            state;
    logic              running;
    logic [31:0]       ir, a_reg, b_reg, alu_out, mdr;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       regs [NREGS];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm, rs_val, rt_val, pc_plus4, jump_pc;
    logic [31:0] alu_b, alu_result;
    logic        alu_zero, legal, regs_bad, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    alu_op_t     alu_op;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign simm     = sign_ext(ir[15:0]);
    assign pc_plus4 = pc + 32'd4;
    assign jump_pc  = {pc_plus4[31:28], ir[25:0], 2'b00};
    assign rs_val   = (rs == 5'd0) ? 32'd0 : regs[rs[IW-1:0]];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : regs[rt[IW-1:0]];

    // running holds the port idle until the first edge after reset releases
    assign mem_req   = running && (state == FETCH || state == MEM);
    assign mem_we    = running && (state == MEM) && (opcode == OP_SW);
    assign mem_addr  = (state == MEM) ? addr_reg : pc[ADDR_W+1:2];
    assign mem_wdata = b_reg;
    assign trap      = (state == TRAP);

    assign alu_op = (opcode == OP_RTYPE) ? funct_to_alu(funct) :
                    (opcode == OP_BEQ)   ? ALU_SUB : ALU_ADD;
    assign alu_b  = (opcode == OP_RTYPE || opcode == OP_BEQ) ? b_reg : simm;

    mips_alu u_alu (
        .op     (alu_op),
        .a      (a_reg),
        .b      (alu_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_comb begin
        legal    = 1'b0;
        regs_bad = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                legal    = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR};
                regs_bad = rs[4] | rt[4] | rd[4];
            end
            OP_LW, OP_SW, OP_BEQ: begin
                legal    = 1'b1;
                regs_bad = rs[4] | rt[4];
            end
            OP_J:    legal = 1'b1;
            OP_JAL: begin
                legal    = 1'b1;
                regs_bad = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        regs_bad = regs_bad && (NREGS == 16);
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = (opcode == OP_LW) ? rt : rd;
        wr_data = (opcode == OP_LW) ? mdr : alu_out;
        if (state == DECODE && opcode == OP_JAL && !regs_bad) begin
            wr_en   = 1'b1;
            wr_addr = 5'd31;
            wr_data = pc_plus4;
        end else if (state == WB) begin
            wr_en = (wr_addr != 5'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= wr_en;
            if (wr_en) begin
                regs[wr_addr[IW-1:0]] <= wr_data;
                rf_waddr              <= wr_addr;
                rf_wdata              <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            running  <= 1'b0;
            pc       <= RESET_PC;
            ir       <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            alu_out  <= '0;
            mdr      <= '0;
            addr_reg <= '0;
        end else begin
            running <= 1'b1;
            case (state)
                FETCH: if (mem_req && mem_ready) begin
                    ir    <= mem_rdata;
                    state <= DECODE;
                end
                DECODE: begin
                    a_reg <= rs_val;
                    b_reg <= rt_val;
                    if (!legal || regs_bad) begin
                        state <= TRAP;
                    end else if (opcode == OP_J || opcode == OP_JAL) begin
                        pc    <= jump_pc;
                        state <= FETCH;
                    end else if (opcode == OP_RTYPE && funct == FN_JR) begin
                        pc    <= rs_val;
                        state <= FETCH;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (opcode == OP_LW || opcode == OP_SW) begin
                        addr_reg <= alu_result[ADDR_W+1:2];
                        state    <= (alu_result[1:0] != 2'b00) ? TRAP : MEM;
                    end else if (opcode == OP_BEQ) begin
                        pc    <= alu_zero ? pc_plus4 + (simm << 2) : pc_plus4;
                        state <= FETCH;
                    end else begin
                        alu_out <= alu_result;
                        state   <= WB;
                    end
                end
                MEM: if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        pc    <= pc_plus4;
                        state <= FETCH;
                    end else begin
                        mdr   <= mem_rdata;
                        state <= WB;
                    end
                end
                WB: begin
                    pc    <= pc_plus4;
                    state <= FETCH;
                end
                default: state <= TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Directed bench: wait-state memory model, register-write scoreboard, latency and trap checks.
module tb_multicycle_mips_core;

    logic        clk;
    logic        rst;
    logic        mem_req, mem_we, mem_ready;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pc;
    logic        trap;

    int total = 0;
    int bad   = 0;
    int wait_cycles = 0;
    logic [31:0] mem [128];

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t sb[$];

    multicycle_mips_core dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pc        (pc),
        .trap      (trap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model: grants after wait_cycles stall cycles and checks request stability while stalled
    initial begin : memory_model
        int          cnt;
        logic        stalled;
        logic [6:0]  s_addr;
        logic        s_we;
        logic [31:0] s_wdata;
        cnt = 0;
        stalled = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst || !mem_req) begin
                mem_ready = 1'b0;
                cnt = 0;
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check_output("stall_addr", {25'd0, mem_addr}, {25'd0, s_addr});
                    check_output("stall_we", {31'd0, mem_we}, {31'd0, s_we});
                    check_output("stall_wdata", mem_wdata, s_wdata);
                end
                if (cnt >= wait_cycles) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    cnt = 0;
                    stalled = 1'b0;
                end else begin
                    mem_ready = 1'b0;
                    cnt++;
                    stalled = 1'b1;
                    s_addr = mem_addr;
                    s_we = mem_we;
                    s_wdata = mem_wdata;
                end
            end
        end
    end

    // Scoreboard: every rf_wen pulse must match the next expected register write
    initial begin : rf_monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && rf_wen) begin
                check_output("rf_write_expected", {31'd0, sb.size() > 0}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_output("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
                    check_output("rf_wdata", rf_wdata, e.data);
                end
            end
        end
    end

    task automatic apply_stimulus(input int waits);
        @(negedge clk);
        rst = 1'b1;
        wait_cycles = waits;
        sb.delete();
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        mem[8] = 32'd5;
        mem[9] = 32'd7;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_fetch(input logic [6:0] word, input int budget, output int cycles);
        int   n;
        logic found;
        n = 0;
        found = 1'b0;
        while (!found && n < budget) begin
            @(negedge clk);
            n++;
            if (mem_req && !mem_we && mem_addr == word && pc == {23'd0, word, 2'b00}) found = 1'b1;
        end
        check_output($sformatf("fetch_w%0d_reached", word), {31'd0, found}, 32'd1);
        cycles = n;
    endtask

    task automatic wait_trap(input string tag, input int expected);
        int n;
        n = 0;
        while (!trap && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, n, expected);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("trap_sticky", {31'd0, trap}, 32'd1);
            check_output("trap_mem_req", {31'd0, mem_req}, 32'd0);
        end
    endtask

    task automatic load_program_a();
        mem[0] = enc_i(6'h23, 5'd0, 5'd1, 16'd32);
        mem[1] = enc_i(6'h23, 5'd0, 5'd2, 16'd36);
        mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        mem[3] = enc_r(5'd2, 5'd1, 5'd4, 6'h2a);
        mem[4] = enc_i(6'h04, 5'd1, 5'd1, 16'hffff);
        sb.push_back({5'd1, 32'd5});
        sb.push_back({5'd2, 32'd7});
        sb.push_back({5'd3, 32'd12});
        sb.push_back({5'd4, 32'd0});
    endtask

    task automatic run_program_a(input int waits, input int exp_cycles, input bit check_loop);
        int c;
        apply_stimulus(waits);
        load_program_a();
        release_reset();
        wait_fetch(7'd0, 10, c);
        wait_fetch(7'd4, 200, c);
        check_output("prog_a_cycles", c, exp_cycles);
        if (check_loop) begin
            wait_fetch(7'd4, 20, c);
            check_output("beq_self_cycles", c, 3);
            check_output("beq_self_pc", pc, 32'd16);
        end
        @(negedge clk);
        check_output("prog_a_drained", sb.size(), 0);
    endtask

    initial begin : main
        int c;
        rst = 1'b1;
        apply_stimulus(3);
        load_program_a();
        repeat (2) @(negedge clk);
        check_output("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check_output("reset_mem_we", {31'd0, mem_we}, 32'd0);
        check_output("reset_rf_wen", {31'd0, rf_wen}, 32'd0);
        check_output("reset_trap", {31'd0, trap}, 32'd0);
        check_output("reset_pc", pc, 32'd0);
        check_output("reset_mem_addr", {25'd0, mem_addr}, 32'd0);
        check_output("reset_mem_wdata", mem_wdata, 32'd0);
        check_output("reset_rf_waddr", {27'd0, rf_waddr}, 32'd0);
        check_output("reset_rf_wdata", rf_wdata, 32'd0);
        rst = 1'b0;
        wait_fetch(7'd0, 5, c);
        check_output("first_fetch_latency", c, 1);
        check_output("first_fetch_addr", {25'd0, mem_addr}, 32'd0);
        #2 rst = 1'b1;
        #1 check_output("reset_mid_fetch_req", {31'd0, mem_req}, 32'd0);
        check_output("reset_mid_fetch_pc", pc, 32'd0);

        $display("[TB] program A, zero wait states");
        run_program_a(0, 18, 1'b1);
        $display("[TB] program A, three wait states per access");
        run_program_a(3, 36, 1'b0);

        $display("[TB] program B: beq, jal/jr, r0, sw/lw, sub/or/and/slt, illegal opcode");
        apply_stimulus(0);
        mem[0]  = enc_i(6'h23, 5'd0, 5'd1, 16'd32);
        mem[1]  = enc_i(6'h23, 5'd0, 5'd2, 16'd36);
        mem[2]  = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
        mem[3]  = {6'h03, 26'd16};
        mem[4]  = enc_r(5'd1, 5'd1, 5'd0, 6'h20);
        mem[5]  = enc_r(5'd0, 5'd1, 5'd6, 6'h20);
        mem[6]  = enc_i(6'h2b, 5'd0, 5'd6, 16'd40);
        mem[7]  = enc_i(6'h23, 5'd0, 5'd7, 16'd40);
        mem[8]  = 32'd5;
        mem[9]  = 32'd7;
        mem[10] = 32'd0;
        mem[16] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
        mem[8]  = 32'd5;
        mem[11] = enc_r(5'd8, 5'd1, 5'd11, 6'h2a);
        mem[12] = 32'hfc00_0000;
        mem[20] = enc_r(5'd1, 5'd2, 5'd8, 6'h22);
        // words 8..10 hold data, so sub/or/and live at 20..22 and jump back to 11
        mem[7]  = {6'h02, 26'd20};
        mem[21] = enc_r(5'd1, 5'd2, 5'd9, 6'h25);
        mem[22] = enc_r(5'd1, 5'd2, 5'd10, 6'h24);
        mem[23] = enc_i(6'h23, 5'd0, 5'd7, 16'd40);
        mem[24] = {6'h02, 26'd11};
        sb.push_back({5'd1, 32'd5});
        sb.push_back({5'd2, 32'd7});
        sb.push_back({5'd31, 32'd16});
        sb.push_back({5'd6, 32'd5});
        sb.push_back({5'd8, 32'hffff_fffe});
        sb.push_back({5'd9, 32'd7});
        sb.push_back({5'd10, 32'd5});
        sb.push_back({5'd7, 32'd5});
        sb.push_back({5'd11, 32'd1});
        release_reset();
        wait_fetch(7'd0, 10, c);
        wait_fetch(7'd2, 40, c);
        wait_fetch(7'd3, 10, c);
        check_output("beq_not_taken_cycles", c, 3);
        wait_fetch(7'd16, 10, c);
        check_output("jal_cycles", c, 2);
        wait_fetch(7'd4, 10, c);
        check_output("jr_cycles", c, 2);
        check_output("jr_return_pc", pc, 32'd16);
        wait_fetch(7'd12, 200, c);
        wait_trap("trap_illegal_latency", 2);
        check_output("sw_stored", mem[10], 32'd5);
        check_output("prog_b_drained", sb.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        #1 check_output("trap_cleared_by_reset", {31'd0, trap}, 32'd0);

        $display("[TB] program C: misaligned lw");
        apply_stimulus(0);
        mem[0] = enc_i(6'h23, 5'd0, 5'd1, 16'd2);
        release_reset();
        wait_fetch(7'd0, 10, c);
        wait_trap("trap_misaligned_latency", 3);
        check_output("prog_c_no_writes", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
